// File: rtl/bitwise_accum.sv
// bitwise_accum: streaming bitwise reducer.
// Folds a frame of WIDTH-bit operands with AND/OR/XOR/NAND and returns one
// result word per frame. A frame ends on in_last or after MAX_LEN beats.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   op                    fold op (00 AND, 01 OR, 10 XOR, 11 NAND), taken on first beat
//   in_valid/in_ready     operand handshake; in_data operand, in_last final beat
//   out_valid/out_ready   result handshake
//   out_data              folded result (inverted for NAND)
//   out_count             beats folded into out_data
//   out_trunc             frame closed by MAX_LEN rather than in_last
module bitwise_accum #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned MAX_LEN = 8,
  localparam int unsigned CW     = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_count,
  output logic             out_trunc
);

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] acc, acc_n;
  logic [CW-1:0]    count, count_n;
  logic [1:0]       op_q, op_n;
  logic [WIDTH-1:0] data_n;
  logic [CW-1:0]    cnt_n;
  logic             trunc_n;
  logic             valid_n;
  logic             ready_n;
  logic [WIDTH-1:0] fold;
  logic [CW-1:0]    count_inc;

  // Fold of the running accumulator with the incoming beat; NAND folds as AND
  always_comb begin
    fold = acc & in_data;
    case (op_q)
      OP_AND:  fold = acc & in_data;
      OP_OR:   fold = acc | in_data;
      OP_XOR:  fold = acc ^ in_data;
      OP_NAND: fold = acc & in_data;
      default: fold = acc & in_data;
    endcase
  end

  assign count_inc = count + CW'(1);

  // Next-state and output decode
  always_comb begin
    state_n = state;
    acc_n   = acc;
    count_n = count;
    op_n    = op_q;
    data_n  = out_data;
    cnt_n   = out_count;
    trunc_n = out_trunc;

    case (state)
      IDLE: begin
        if (in_valid) begin
          acc_n   = in_data;
          count_n = CW'(1);
          op_n    = op;
          if (in_last) begin
            state_n = DONE;
            data_n  = (op == OP_NAND) ? ~in_data : in_data;
            cnt_n   = CW'(1);
            trunc_n = 1'b0;
          end else begin
            state_n = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_n   = fold;
          count_n = count_inc;
          // Close on in_last, or force-close when the frame hits MAX_LEN
          if (in_last || (count_inc == CW'(MAX_LEN))) begin
            state_n = DONE;
            data_n  = (op_q == OP_NAND) ? ~fold : fold;
            cnt_n   = count_inc;
            trunc_n = ~in_last;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_n = IDLE;
          trunc_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase

    // Handshake flags are pure decodes of the next state, so they register cleanly
    valid_n = (state_n == DONE);
    ready_n = (state_n != DONE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      op_q      <= OP_AND;
      out_data  <= '0;
      out_count <= '0;
      out_trunc <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      count     <= count_n;
      op_q      <= op_n;
      out_data  <= data_n;
      out_count <= cnt_n;
      out_trunc <= trunc_n;
      out_valid <= valid_n;
      in_ready  <= ready_n;
    end
  end

endmodule

// File: tb/tb_bitwise_accum.sv
// tb_bitwise_accum: directed and randomized check of bitwise_accum against a
// frame-level reference model (beats collected per frame, folded at frame end).
module tb_bitwise_accum;

  localparam int unsigned W  = 16;
  localparam int unsigned ML = 8;
  localparam int unsigned CW = $clog2(ML + 1);

  logic          clk;
  logic          rst;
  logic [1:0]    op;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_count;
  logic          out_trunc;

  bitwise_accum #(.WIDTH(W), .MAX_LEN(ML)) dut (
    .clk(clk), .rst(rst), .op(op),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .out_trunc(out_trunc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    int           cnt;
    logic         trunc;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] cur_beats[$];
  logic [1:0]   cur_op;
  int           total = 0;
  int           bad = 0;
  int           beats_in = 0;
  int           beats_out = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reduce a whole frame from its list of beats
  function automatic logic [W-1:0] fold_frame(input logic [1:0] o, input logic [W-1:0] b[$]);
    logic [W-1:0] r;
    r = b[0];
    for (int i = 1; i < b.size(); i++) begin
      case (o)
        2'b01:   r = r | b[i];
        2'b10:   r = r ^ b[i];
        default: r = r & b[i];
      endcase
    end
    return (o == 2'b11) ? ~r : r;
  endfunction

  task automatic model_beat(input logic [W-1:0] d, input logic l, input logic [1:0] o);
    exp_t e;
    beats_in++;
    if (cur_beats.size() == 0) cur_op = o;
    cur_beats.push_back(d);
    if (l || cur_beats.size() == ML) begin
      e.data  = fold_frame(cur_op, cur_beats);
      e.cnt   = cur_beats.size();
      e.trunc = ~l;
      exp_q.push_back(e);
      cur_beats.delete();
    end
  endtask

  // One clock: drive at negedge, compare status and any transfer, advance to next negedge
  task automatic step(input logic v, input logic [W-1:0] d, input logic l,
                      input logic [1:0] o, input logic r, output logic accepted);
    exp_t e;
    in_valid = v; in_data = d; in_last = l; op = o; out_ready = r;
    #1;
    check("in_ready", 32'(in_ready), 32'(exp_q.size() == 0));
    check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    accepted = v && in_ready;
    if (out_valid && r) begin
      if (exp_q.size() == 0) begin
        check("spurious_result", 32'(1), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check("out_data", 32'(out_data), 32'(e.data));
        check("out_count", 32'(out_count), 32'(e.cnt));
        check("out_trunc", 32'(out_trunc), 32'(e.trunc));
        beats_out += int'(out_count);
      end
    end
    if (accepted) model_beat(d, l, o);
    @(posedge clk);
    @(negedge clk);
  endtask

  logic         a;
  logic [W-1:0] pend_data;
  int           tgt, idx, frames_gen, cycles;
  logic         pend_last;

  initial begin
    rst = 1'b1; op = 2'b00; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_out_data", 32'(out_data), 32'(0));
    rst = 1'b0;

    // Reset mid-frame discards the partial frame
    step(1'b1, 16'h00F0, 1'b0, 2'b01, 1'b0, a);
    step(1'b1, 16'h0F00, 1'b0, 2'b01, 1'b0, a);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'(0));
    check("midrst_in_ready", 32'(in_ready), 32'(1));
    check("midrst_out_data", 32'(out_data), 32'(0));
    check("midrst_out_count", 32'(out_count), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    cur_beats.delete();
    exp_q.delete();
    beats_in = 0;
    step(1'b1, 16'h1234, 1'b1, 2'b00, 1'b0, a);
    check("single_data", 32'(out_data), 32'h1234);
    check("single_count", 32'(out_count), 32'd1);
    step(1'b0, '0, 1'b0, 2'b00, 1'b1, a);

    // OR frame, result one cycle after last beat, gone the cycle after transfer
    step(1'b1, 16'h0001, 1'b0, 2'b01, 1'b1, a);
    step(1'b1, 16'h0002, 1'b0, 2'b01, 1'b1, a);
    step(1'b1, 16'h8000, 1'b1, 2'b01, 1'b1, a);
    check("or_valid", 32'(out_valid), 32'd1);
    check("or_data", 32'(out_data), 32'h8003);
    check("or_count", 32'(out_count), 32'd3);
    check("or_trunc", 32'(out_trunc), 32'd0);
    step(1'b0, '0, 1'b0, 2'b01, 1'b1, a);
    check("or_valid_drop", 32'(out_valid), 32'd0);

    // AND frame held under backpressure
    step(1'b1, 16'hFFFF, 1'b0, 2'b00, 1'b0, a);
    step(1'b1, 16'h0F0F, 1'b1, 2'b00, 1'b0, a);
    for (int i = 0; i < 5; i++) begin
      check("bp_data", 32'(out_data), 32'h0F0F);
      step(1'b1, 16'hAAAA, 1'b0, 2'b00, 1'b0, a);
    end
    step(1'b0, '0, 1'b0, 2'b00, 1'b1, a);
    check("bp_released", 32'(out_valid), 32'd0);

    // XOR frame truncated at MAX_LEN; ninth beat opens a new frame
    for (int i = 0; i < 8; i++) step(1'b1, 16'h0001, 1'b0, 2'b10, 1'b0, a);
    check("trunc_data", 32'(out_data), 32'h0000);
    check("trunc_count", 32'(out_count), 32'd8);
    check("trunc_flag", 32'(out_trunc), 32'd1);
    step(1'b1, 16'h0001, 1'b1, 2'b10, 1'b1, a);
    check("trunc_beat9_held", 32'(a), 32'd0);
    step(1'b1, 16'h0001, 1'b1, 2'b10, 1'b0, a);
    check("after_data", 32'(out_data), 32'h0001);
    check("after_count", 32'(out_count), 32'd1);
    check("after_trunc", 32'(out_trunc), 32'd0);
    step(1'b0, '0, 1'b0, 2'b10, 1'b1, a);

    // NAND latched on first beat, later op change ignored
    step(1'b1, 16'hFF00, 1'b0, 2'b11, 1'b0, a);
    step(1'b1, 16'hF0F0, 1'b1, 2'b01, 1'b0, a);
    check("nand_data", 32'(out_data), 32'h0FFF);
    step(1'b0, '0, 1'b0, 2'b01, 1'b1, a);

    // Random frames with random valid/ready gaps and random op toggling
    frames_gen = 0; idx = 0; cycles = 0;
    tgt = $urandom_range(1, 10);
    pend_data = W'($urandom);
    pend_last = (tgt == 1);
    while ((frames_gen < 1000 || exp_q.size() != 0 || cur_beats.size() != 0) && cycles < 60000) begin
      step((frames_gen < 1000) && ($urandom_range(0, 3) != 0), pend_data, pend_last,
           2'($urandom), $urandom_range(0, 1) == 1, a);
      cycles++;
      if (a) begin
        if (pend_last) begin
          frames_gen++;
          idx = 0;
          tgt = $urandom_range(1, 10);
        end else begin
          idx++;
        end
        pend_data = W'($urandom);
        pend_last = (idx == tgt - 1);
      end
    end
    check("random_budget", 32'(cycles < 60000), 32'd1);
    check("beat_conservation", 32'(beats_out), 32'(beats_in));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
